// File: rtl/niosii_sysid_ext.sv
// Avalon-MM system ID block: ID/timestamp words, 64-bit uptime counter with an
// atomically captured HI shadow, scratch and control registers, user status words.
module niosii_sysid_ext #(
  parameter logic [31:0] ID_VALUE   = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP  = 32'h0000_0000,
  parameter int          NUM_USER   = 2,
  parameter int          ADDR_WIDTH = 4
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic [ADDR_WIDTH-1:0]                       address,
  input  logic                                        read,
  input  logic                                        write,
  input  logic [31:0]                                 writedata,
  input  logic [3:0]                                  byteenable,
  output logic [31:0]                                 readdata,
  output logic                                        readdatavalid,
  input  logic [((NUM_USER > 0) ? NUM_USER : 1)*32-1:0] user_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ID      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TSTAMP  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_UPLO    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_UPHI    = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_SCRATCH = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL    = ADDR_WIDTH'(5);

  generate
    if (NUM_USER < 0 || NUM_USER > 8) begin : g_numUserCheck
      $error("niosii_sysid_ext: NUM_USER must be in 0..8");
    end
    if (ADDR_WIDTH < 31 && (2 ** ADDR_WIDTH) < (6 + NUM_USER)) begin : g_addrCheck
      $error("niosii_sysid_ext: ADDR_WIDTH too small for the register map");
    end
    if (NUM_USER == 0) begin : g_noUser
      logic w_unusedUser;
      assign w_unusedUser = ^user_data;
    end
  endgenerate

  logic [63:0] r_counter;
  logic [31:0] r_hiShadow;
  logic [31:0] r_scratch;
  logic        r_ctrlEnable;
  logic [31:0] r_readdata;
  logic        r_rdValid;

  logic [31:0] w_rdata;
  logic        w_wrScratch;
  logic        w_wrControl;
  logic        w_clear;

  assign w_wrScratch = write && (address == ADDR_SCRATCH);
  assign w_wrControl = write && (address == ADDR_CTRL) && byteenable[0];
  assign w_clear     = w_wrControl && writedata[1];

  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_ID:      w_rdata = ID_VALUE;
      ADDR_TSTAMP:  w_rdata = TIMESTAMP;
      ADDR_UPLO:    w_rdata = r_counter[31:0];
      ADDR_UPHI:    w_rdata = r_hiShadow;
      ADDR_SCRATCH: w_rdata = r_scratch;
      ADDR_CTRL:    w_rdata = {31'b0, r_ctrlEnable};
      default:      w_rdata = '0;
    endcase
    for (int k = 0; k < NUM_USER; k++) begin
      if (address == ADDR_WIDTH'(6 + k)) w_rdata = user_data[32*k +: 32];
    end
  end

  // Read data is captured from pre-write state, so a same-cycle write is seen by the next read only.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_counter    <= '0;
      r_hiShadow   <= '0;
      r_scratch    <= '0;
      r_ctrlEnable <= 1'b1;
      r_readdata   <= '0;
      r_rdValid    <= 1'b0;
    end else begin
      r_rdValid <= read;
      if (read) begin
        r_readdata <= w_rdata;
        if (address == ADDR_UPLO) r_hiShadow <= r_counter[63:32];
      end
      if (w_wrScratch) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) r_scratch[8*b +: 8] <= writedata[8*b +: 8];
        end
      end
      if (w_wrControl) r_ctrlEnable <= writedata[0];
      if (w_clear) r_counter <= '0;
      else if (r_ctrlEnable) r_counter <= r_counter + 64'd1;
    end
  end

  assign readdata = r_readdata;
  // A response landing in the cycle reset is raised belongs to a dropped read.
  assign readdatavalid = r_rdValid && !reset;

endmodule

// File: tb/tb_niosii_sysid_ext.sv
// Directed self-checking bench for niosii_sysid_ext: register map, uptime
// shadow across the 32-bit carry, scratch byte enables, control and reset.
module tb_niosii_sysid_ext;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [63:0] user_data = '0;

  int checkCount = 0;
  int errorCount = 0;
  logic [31:0] rd;
  logic        rv;

  niosii_sysid_ext #(
    .ID_VALUE(32'h5896_A7CD),
    .TIMESTAMP(32'h6543_0000),
    .NUM_USER(2),
    .ADDR_WIDTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .byteenable(byteenable),
    .readdata(readdata),
    .readdatavalid(readdatavalid),
    .user_data(user_data)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got running want finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic busWrite(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(posedge clock); #1;
    write = 1'b0; byteenable = '0;
  endtask

  task automatic busRead(input logic [3:0] a, output logic [31:0] d, output logic v);
    address = a; read = 1'b1;
    @(posedge clock); #1;
    read = 1'b0; d = readdata; v = readdatavalid;
  endtask

  task automatic busReadWrite(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be,
                              output logic [31:0] d, output logic v);
    address = a; writedata = wd; byteenable = be; read = 1'b1; write = 1'b1;
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0; byteenable = '0; d = readdata; v = readdatavalid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkCount++;
    if (readdata !== 32'h0 || readdatavalid !== 1'b0) begin
      errorCount++; $display("[TB] FAIL reset_out got %h/%b want 00000000/0", readdata, readdatavalid);
    end
    reset = 1'b0;
    busRead(4'd2, rd, rv);
    checkCount++;
    if (rd !== 32'h0 || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL reset_uplo got %h/%b want 00000000/1", rd, rv);
    end
    busRead(4'd3, rd, rv);
    checkCount++;
    if (rd !== 32'h0 || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL reset_uphi got %h/%b want 00000000/1", rd, rv);
    end
    busRead(4'd4, rd, rv);
    checkCount++;
    if (rd !== 32'h0 || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL reset_scratch got %h/%b want 00000000/1", rd, rv);
    end
    busRead(4'd5, rd, rv);
    checkCount++;
    if (rd !== 32'h1 || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL reset_control got %h/%b want 00000001/1", rd, rv);
    end
  endtask

  task automatic test_id();
    @(posedge clock); #1;
    checkCount++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h1) begin
      errorCount++; $display("[TB] FAIL hold_idle got %h/%b want 00000001/0", readdata, readdatavalid);
    end
    busRead(4'd0, rd, rv);
    checkCount++;
    if (rd !== 32'h5896_A7CD || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL id got %h/%b want 5896a7cd/1", rd, rv);
    end
    @(posedge clock); #1;
    checkCount++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h5896_A7CD) begin
      errorCount++; $display("[TB] FAIL id_single_valid got %h/%b want 5896a7cd/0", readdata, readdatavalid);
    end
    busRead(4'd1, rd, rv);
    checkCount++;
    if (rd !== 32'h6543_0000 || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL timestamp got %h/%b want 65430000/1", rd, rv);
    end
    busWrite(4'd0, 32'hFFFF_FFFF, 4'hF);
    busRead(4'd0, rd, rv);
    checkCount++;
    if (rd !== 32'h5896_A7CD) begin
      errorCount++; $display("[TB] FAIL id_readonly got %h want 5896a7cd", rd);
    end
    busWrite(4'd9, 32'h1234_5678, 4'hF);
    busRead(4'd9, rd, rv);
    checkCount++;
    if (rd !== 32'h0 || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL unmapped9 got %h/%b want 00000000/1", rd, rv);
    end
    busRead(4'd15, rd, rv);
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++; $display("[TB] FAIL unmapped15 got %h want 00000000", rd);
    end
  endtask

  task automatic test_user();
    user_data = {32'hBEEF_0001, 32'hCAFE_0000};
    busRead(4'd6, rd, rv);
    checkCount++;
    if (rd !== 32'hCAFE_0000 || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL user0 got %h/%b want cafe0000/1", rd, rv);
    end
    busRead(4'd7, rd, rv);
    checkCount++;
    if (rd !== 32'hBEEF_0001) begin
      errorCount++; $display("[TB] FAIL user1 got %h want beef0001", rd);
    end
    busRead(4'd8, rd, rv);
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++; $display("[TB] FAIL user_beyond got %h want 00000000", rd);
    end
    address = 4'd6; read = 1'b1; user_data[31:0] = 32'h1111_1111;
    @(posedge clock); #1;
    read = 1'b0; user_data[31:0] = 32'h2222_2222;
    checkCount++;
    if (readdata !== 32'h1111_1111 || readdatavalid !== 1'b1) begin
      errorCount++; $display("[TB] FAIL user_sample got %h/%b want 11111111/1", readdata, readdatavalid);
    end
    @(posedge clock); #1;
    checkCount++;
    if (readdata !== 32'h1111_1111 || readdatavalid !== 1'b0) begin
      errorCount++; $display("[TB] FAIL user_hold got %h/%b want 11111111/0", readdata, readdatavalid);
    end
  endtask

  task automatic test_scratch();
    busWrite(4'd4, 32'hFFFF_FFFF, 4'hF);
    busWrite(4'd4, 32'h1234_5678, 4'b0101);
    busRead(4'd4, rd, rv);
    checkCount++;
    if (rd !== 32'hFF34_FF78) begin
      errorCount++; $display("[TB] FAIL scratch_be got %h want ff34ff78", rd);
    end
    busWrite(4'd4, 32'h0000_0000, 4'b0000);
    busRead(4'd4, rd, rv);
    checkCount++;
    if (rd !== 32'hFF34_FF78) begin
      errorCount++; $display("[TB] FAIL scratch_be0 got %h want ff34ff78", rd);
    end
    busReadWrite(4'd4, 32'hAAAA_5555, 4'hF, rd, rv);
    checkCount++;
    if (rd !== 32'hFF34_FF78 || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL scratch_rw_old got %h/%b want ff34ff78/1", rd, rv);
    end
    busRead(4'd4, rd, rv);
    checkCount++;
    if (rd !== 32'hAAAA_5555) begin
      errorCount++; $display("[TB] FAIL scratch_rw_new got %h want aaaa5555", rd);
    end
  endtask

  task automatic test_uptime();
    busWrite(4'd5, 32'h0, 4'hF);
    force dut.r_counter = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.r_counter;
    repeat (10) @(posedge clock);
    #1;
    busRead(4'd2, rd, rv);
    checkCount++;
    if (rd !== 32'hFFFF_FFFE) begin
      errorCount++; $display("[TB] FAIL uptime_frozen_lo got %h want fffffffe", rd);
    end
    busRead(4'd3, rd, rv);
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++; $display("[TB] FAIL uptime_frozen_hi got %h want 00000000", rd);
    end
    busWrite(4'd5, 32'h1, 4'hF);
    busRead(4'd2, rd, rv);
    checkCount++;
    if (rd !== 32'hFFFF_FFFE) begin
      errorCount++; $display("[TB] FAIL uptime_pre_lo got %h want fffffffe", rd);
    end
    busRead(4'd3, rd, rv);
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++; $display("[TB] FAIL uptime_shadow_hi got %h want 00000000", rd);
    end
    busRead(4'd2, rd, rv);
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++; $display("[TB] FAIL uptime_post_lo got %h want 00000000", rd);
    end
    busRead(4'd3, rd, rv);
    checkCount++;
    if (rd !== 32'h1) begin
      errorCount++; $display("[TB] FAIL uptime_post_hi got %h want 00000001", rd);
    end
  endtask

  task automatic test_control();
    busWrite(4'd5, 32'h0, 4'b1110);
    busRead(4'd5, rd, rv);
    checkCount++;
    if (rd !== 32'h1) begin
      errorCount++; $display("[TB] FAIL control_be0 got %h want 00000001", rd);
    end
    busWrite(4'd5, 32'hFFFF_FFFD, 4'hF);
    busRead(4'd5, rd, rv);
    checkCount++;
    if (rd !== 32'h1) begin
      errorCount++; $display("[TB] FAIL control_upper got %h want 00000001", rd);
    end
    busWrite(4'd5, 32'h3, 4'h1);
    busRead(4'd2, rd, rv);
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++; $display("[TB] FAIL control_clear got %h want 00000000", rd);
    end
    busRead(4'd5, rd, rv);
    checkCount++;
    if (rd !== 32'h1) begin
      errorCount++; $display("[TB] FAIL control_after_clear got %h want 00000001", rd);
    end
  endtask

  task automatic test_back_to_back_reset();
    address = 4'd4; read = 1'b1;
    @(posedge clock); #1;
    reset = 1'b1; write = 1'b1; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
    #1;
    checkCount++;
    if (readdatavalid !== 1'b0) begin
      errorCount++; $display("[TB] FAIL reset_drop_prev got %b want 0", readdatavalid);
    end
    @(posedge clock); #1;
    reset = 1'b0; read = 1'b0; write = 1'b0; byteenable = '0;
    checkCount++;
    if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
      errorCount++; $display("[TB] FAIL reset_cycle_out got %h/%b want 00000000/0", readdata, readdatavalid);
    end
    @(posedge clock); #1;
    checkCount++;
    if (readdatavalid !== 1'b0) begin
      errorCount++; $display("[TB] FAIL reset_drop_same got %b want 0", readdatavalid);
    end
    busRead(4'd2, rd, rv);
    checkCount++;
    if (rd !== 32'h1 || rv !== 1'b1) begin
      errorCount++; $display("[TB] FAIL reset_restart_lo got %h/%b want 00000001/1", rd, rv);
    end
    busRead(4'd3, rd, rv);
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++; $display("[TB] FAIL reset_restart_hi got %h want 00000000", rd);
    end
    busRead(4'd4, rd, rv);
    checkCount++;
    if (rd !== 32'h0) begin
      errorCount++; $display("[TB] FAIL reset_scratch_prio got %h want 00000000", rd);
    end
    busRead(4'd5, rd, rv);
    checkCount++;
    if (rd !== 32'h1) begin
      errorCount++; $display("[TB] FAIL reset_control got %h want 00000001", rd);
    end
  endtask

  initial begin
    test_reset();
    test_id();
    test_user();
    test_scratch();
    test_uptime();
    test_control();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
